// File: rtl/jbi_l2_rptr_pipe.sv
// Registered repeater between JBI and one L2 bank, with a conservative IQ occupancy
// counter that gives JBI a local full indication and credit over/underflow flags.
module jbi_l2_rptr_pipe #(
   parameter int unsigned REQ_STAGES = 2,
   parameter int unsigned RTN_STAGES = 2,
   parameter int unsigned IQ_DEPTH   = 16,
   parameter int unsigned CW         = $clog2(IQ_DEPTH + 1)
) (
   input  logic          rclk,
   input  logic          arst_l,
   input  logic [31:0]   jbi_sctag_req,
   input  logic [6:0]    jbi_scbuf_ecc,
   input  logic          jbi_sctag_req_vld,
   input  logic [31:0]   scbuf_jbi_data,
   input  logic          scbuf_jbi_ctag_vld,
   input  logic          scbuf_jbi_ue_err,
   input  logic          sctag_jbi_iq_dequeue,
   input  logic          sctag_jbi_wib_dequeue,
   input  logic          sctag_jbi_por_req,
   output logic [31:0]   jbi_sctag_req_buf,
   output logic [6:0]    jbi_scbuf_ecc_buf,
   output logic          jbi_sctag_req_vld_buf,
   output logic [31:0]   scbuf_jbi_data_buf,
   output logic          scbuf_jbi_ctag_vld_buf,
   output logic          scbuf_jbi_ue_err_buf,
   output logic          sctag_jbi_iq_dequeue_buf,
   output logic          sctag_jbi_wib_dequeue_buf,
   output logic          sctag_jbi_por_req_buf,
   output logic [CW-1:0] jbi_iq_cnt,
   output logic          jbi_iq_full,
   output logic          jbi_iq_ovf_err,
   output logic          jbi_iq_udf_err
);

   localparam int unsigned REQ_W = 40;
   localparam int unsigned RTN_W = 37;
   localparam logic [CW-1:0] CNT_MAX = CW'(IQ_DEPTH);

   logic [REQ_W-1:0] req_in;
   logic [RTN_W-1:0] rtn_in;
   logic [REQ_STAGES-1:0][REQ_W-1:0] req_q;
   logic [RTN_STAGES-1:0][RTN_W-1:0] rtn_q;

   logic [CW-1:0] cnt_q, cnt_d;
   logic          ovf_q, ovf_d;
   logic          udf_q, udf_d;
   logic          inc, dec;

   assign req_in = {jbi_sctag_req, jbi_scbuf_ecc, jbi_sctag_req_vld};
   assign rtn_in = {scbuf_jbi_data, scbuf_jbi_ctag_vld, scbuf_jbi_ue_err,
                    sctag_jbi_iq_dequeue, sctag_jbi_wib_dequeue, sctag_jbi_por_req};

   // Stages load unconditionally: data beats trail their header without their own valid.
   always_ff @(posedge rclk or negedge arst_l) begin
      if (!arst_l) begin
         req_q <= '0;
         rtn_q <= '0;
      end else begin
         req_q[0] <= req_in;
         for (int i = 1; i < int'(REQ_STAGES); i++) req_q[i] <= req_q[i-1];
         rtn_q[0] <= rtn_in;
         for (int i = 1; i < int'(RTN_STAGES); i++) rtn_q[i] <= rtn_q[i-1];
      end
   end

   assign {jbi_sctag_req_buf, jbi_scbuf_ecc_buf, jbi_sctag_req_vld_buf} = req_q[REQ_STAGES-1];
   assign {scbuf_jbi_data_buf, scbuf_jbi_ctag_vld_buf, scbuf_jbi_ue_err_buf,
           sctag_jbi_iq_dequeue_buf, sctag_jbi_wib_dequeue_buf,
           sctag_jbi_por_req_buf} = rtn_q[RTN_STAGES-1];

   // Increment before the request pipe, decrement after the return pipe: count never under-reports.
   assign inc = jbi_sctag_req_vld;
   assign dec = sctag_jbi_iq_dequeue_buf;

   always_comb begin
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      udf_d = udf_q;
      if (inc && !dec) begin
         if (cnt_q == CNT_MAX) ovf_d = 1'b1;
         else                  cnt_d = cnt_q + CW'(1);
      end else if (dec && !inc) begin
         if (cnt_q == '0) udf_d = 1'b1;
         else             cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge rclk or negedge arst_l) begin
      if (!arst_l) begin
         cnt_q <= '0;
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
         udf_q <= udf_d;
      end
   end

   assign jbi_iq_cnt     = cnt_q;
   assign jbi_iq_full    = (cnt_q == CNT_MAX);
   assign jbi_iq_ovf_err = ovf_q;
   assign jbi_iq_udf_err = udf_q;

endmodule
